// File: rtl/normalizador_fp.sv
// Normalize / round-to-nearest-even / pack stage for single-precision results.
// Takes an unnormalized sign/exponent/mantissa+GRS triple and emits an IEEE-754 word plus flags.
module normalizador_fp (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sinal,
  input  logic [7:0]  in_expoente,
  input  logic [27:0] in_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_resultado,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_CHECK, S_DONE} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [8:0]  e_q;
  logic [27:0] m_q;
  logic        valid_q;
  logic [31:0] res_q;
  logic        ovf_q;
  logic        unf_q;
  logic        inex_q;

  logic [8:0]  e_inc;
  logic [8:0]  e_dec;
  logic [27:0] m_shr;
  logic [27:0] m_shl;
  logic [27:0] m_rnd;
  logic        rnd_inc;

  // Exponent kept 9 bits wide so 255 and <=1 are detected without wrap-around.
  assign e_inc   = e_q + 9'd1;
  assign e_dec   = e_q - 9'd1;
  assign m_shr   = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
  assign m_shl   = {m_q[26:0], 1'b0};
  assign m_rnd   = m_q + 28'h8;
  assign rnd_inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = valid_q;
  assign out_resultado = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inex_q;

  // NOTE: state uses non-blocking assignments only; reset is asynchronous so
  // out_valid drops the moment reset rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inex_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sinal;
            e_q    <= {1'b0, in_expoente};
            m_q    <= in_mantissa;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inex_q <= 1'b0;
            if (in_mantissa == '0) begin
              res_q   <= {in_sinal, 31'b0};
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else if (in_expoente == 8'hFF) begin
              res_q   <= {in_sinal, 8'hFF, 23'b0};
              ovf_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (m_q[27]) begin
            m_q <= m_shr;
            e_q <= e_inc;
            if (e_inc == 9'd255) begin
              res_q   <= {sign_q, 8'hFF, 23'b0};
              ovf_q   <= 1'b1;
              inex_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ROUND;
            end
          end else if (!m_q[26]) begin
            if (e_q <= 9'd1) begin
              // Flush to zero: no denormal support.
              res_q   <= {sign_q, 31'b0};
              unf_q   <= 1'b1;
              inex_q  <= |m_q;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              m_q <= m_shl;
              e_q <= e_dec;
            end
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (rnd_inc) m_q <= m_rnd;
          inex_q  <= |m_q[2:0];
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          valid_q <= 1'b1;
          state_q <= S_DONE;
          if (m_q[27]) begin
            m_q <= m_shr;
            e_q <= e_inc;
            if (e_inc == 9'd255) begin
              res_q <= {sign_q, 8'hFF, 23'b0};
              ovf_q <= 1'b1;
            end else begin
              res_q <= {sign_q, e_inc[7:0], m_shr[25:3]};
            end
          end else begin
            res_q <= {sign_q, e_q[7:0], m_q[25:3]};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizador_fp.sv
// Directed-vector bench for normalizador_fp: driver pushes expectations into a
// queue, an independent monitor pops and compares on each output handshake.
module tb_normalizador_fp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sinal;
  logic [7:0]  in_expoente;
  logic [27:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_resultado;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inex;
    int          lat;   // -1 when latency is not checked
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  normalizador_fp dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sinal(in_sinal), .in_expoente(in_expoente), .in_mantissa(in_mantissa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_resultado(out_resultado), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares at negedge, away from the active edge.
  initial begin : monitor
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            if (q[0].lat >= 0) check("latency", cyc - acc_cyc, q[0].lat);
          end
          if (!out_ready) begin
            check("hold_resultado", out_resultado, q[0].res);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
          end else begin
            check("resultado", out_resultado, q[0].res);
            check("overflow", {31'b0, out_overflow}, {31'b0, q[0].ovf});
            check("underflow", {31'b0, out_underflow}, {31'b0, q[0].unf});
            check("inexact", {31'b0, out_inexact}, {31'b0, q[0].inex});
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                      input logic [31:0] r, input logic ov, input logic un,
                      input logic ix, input int lat, input int stall);
    exp_t x;
    int n;
    x.res = r; x.ovf = ov; x.unf = un; x.inex = ix; x.lat = lat;
    q.push_back(x);
    @(negedge clk);
    in_sinal    = s;
    in_expoente = e;
    in_mantissa = m;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'b0, in_ready}, 32'd1);
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = (stall == 0);
    if (stall > 0) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      repeat (stall) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'b0, n < 200}, 32'd1);
    if (n >= 200) q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sinal    = 1'b0;
    in_expoente = '0;
    in_mantissa = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_resultado", out_resultado, 32'd0);
    check("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // sign, exp, mant, expected result, ovf, unf, inex, latency, stall cycles
    send(0, 8'h7F, 28'h4000000, 32'h3F800000, 0, 0, 0, 3, 0);
    send(0, 8'h7F, 28'h4000000, 32'h3F800000, 0, 0, 0, 3, 5);
    send(0, 8'h7F, 28'h8000000, 32'h40000000, 0, 0, 0, -1, 0);
    send(0, 8'hFE, 28'h8000000, 32'h7F800000, 1, 0, 1, -1, 0);
    send(0, 8'h82, 28'h0800000, 32'h3F800000, 0, 0, 0, 6, 0);
    send(0, 8'h02, 28'h0100000, 32'h00000000, 0, 1, 1, -1, 0);
    send(0, 8'h7F, 28'h4000004, 32'h3F800000, 0, 0, 1, 3, 0);
    send(0, 8'h7F, 28'h400000C, 32'h3F800002, 0, 0, 1, 3, 0);
    send(0, 8'h7F, 28'h4000006, 32'h3F800001, 0, 0, 1, 3, 0);
    send(0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 0, 0, 1, -1, 0);
    send(0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 1, 0, 1, -1, 0);
    send(1, 8'h45, 28'h0000000, 32'h80000000, 0, 0, 0, -1, 0);
    send(1, 8'hFF, 28'h4000000, 32'hFF800000, 1, 0, 0, -1, 0);

    // Reset while a 10-shift operand is being normalized; no result expected.
    @(negedge clk);
    in_sinal    = 1'b0;
    in_expoente = 8'h89;
    in_mantissa = 28'h0010000;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_resultado", out_resultado, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(0, 8'h89, 28'h0010000, 32'h3F800000, 0, 0, 0, 13, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
